tl45_alu: RTL and testbench

//  Execute stage directly upstream of the memory stage. Computes ALU results and flags,

---
 rtl/tl45_pkg.sv | 53 +++++
 rtl/tl45_mul_iter.sv | 72 +++++++
 rtl/tl45_alu.sv | 195 +++++++++++++++++++
 tb/tb_tl45_alu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_pkg.sv
// Shared definitions for the TL45 pipeline: opcodes, jump condition codes,
// multiplier FSM states and the jump condition evaluator.
package tl45_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h06;
  localparam logic [4:0] OP_XOR = 5'h07;
  localparam logic [4:0] OP_AND = 5'h08;
  localparam logic [4:0] OP_NOT = 5'h09;
  localparam logic [4:0] OP_SHL = 5'h0A;
  localparam logic [4:0] OP_SHR = 5'h0B;
  localparam logic [4:0] OP_JMP = 5'h0C;
  localparam logic [4:0] OP_IN  = 5'h10;
  localparam logic [4:0] OP_OUT = 5'h11;
  localparam logic [4:0] OP_LW  = 5'h14;
  localparam logic [4:0] OP_SW  = 5'h15;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_Z      = 4'h1;
  localparam logic [3:0] COND_NZ     = 4'h2;
  localparam logic [3:0] COND_N      = 4'h3;
  localparam logic [3:0] COND_NN     = 4'h4;
  localparam logic [3:0] COND_C      = 4'h5;
  localparam logic [3:0] COND_V      = 4'h6;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Codes 7..F never take the jump.
  function automatic logic cond_met(input logic [3:0] cond, input logic z, input logic n,
                                    input logic c, input logic v);
    logic r;
    r = 1'b0;
    case (cond)
      COND_ALWAYS: r = 1'b1;
      COND_Z:      r = z;
      COND_NZ:     r = ~z;
      COND_N:      r = n;
      COND_NN:     r = ~n;
      COND_C:      r = c;
      COND_V:      r = v;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tl45_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over 32 cycles,
// then holds the low 32 bits of the product until acknowledged.
module tl45_mul_iter
  import tl45_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  mul_state_t  r_state;
  mul_state_t  w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [4:0]  r_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= MUL_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic: start -> 32 iterations -> hold result until ack.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MUL_IDLE: begin
        if (i_start) w_next = MUL_BUSY;
        else         w_next = MUL_IDLE;
      end
      MUL_BUSY: begin
        if (r_count == 5'd31) w_next = MUL_DONE;
        else                  w_next = MUL_BUSY;
      end
      MUL_DONE: begin
        if (i_ack) w_next = MUL_IDLE;
        else       w_next = MUL_DONE;
      end
      default: w_next = MUL_IDLE;
    endcase
  end

  // Operand latch and accumulate one partial product per busy cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_acc   <= 32'd0;
      r_count <= 5'd0;
    end else if (r_state == MUL_IDLE && i_start) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_acc   <= 32'd0;
      r_count <= 5'd0;
    end else if (r_state == MUL_BUSY) begin
      if (r_a[r_count]) r_acc <= r_acc + (r_b << r_count);
      r_count <= r_count + 5'd1;
    end
  end

  assign o_busy   = (r_state == MUL_BUSY);
  assign o_done   = (r_state == MUL_DONE);
  assign o_result = r_acc;

endmodule

// File: rtl/tl45_alu.sv
// TL45 execute stage: ALU with ZNCV flags, conditional jump resolution with
// wrong-path squash, iterative multiplier, and the buffer feeding the memory stage.
module tl45_alu
  import tl45_pkg::*;
#(
  parameter int MUL_ENABLE = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  output logic        o_pipe_stall,
  input  logic [4:0]  i_buf_opcode,
  input  logic [3:0]  i_buf_cond,
  input  logic [3:0]  i_buf_dr,
  input  logic [31:0] i_buf_sr1_val,
  input  logic [31:0] i_buf_sr2_val,
  input  logic [31:0] i_buf_imm,
  output logic [4:0]  o_buf_opcode,
  output logic [3:0]  o_buf_dr,
  output logic [31:0] o_buf_sr1_val,
  output logic [31:0] o_buf_sr2_val,
  output logic [31:0] o_buf_imm,
  output logic [3:0]  o_fwd_dr,
  output logic [31:0] o_fwd_val,
  output logic        o_branch_valid,
  output logic [31:0] o_branch_pc
);

  logic [4:0]  r_opcode;
  logic [3:0]  r_dr;
  logic [31:0] r_sr1_val;
  logic [31:0] r_sr2_val;
  logic [31:0] r_imm;
  logic [3:0]  r_fwd_dr;
  logic        r_branch_valid;
  logic [31:0] r_branch_pc;
  logic        r_squash;
  logic        r_z, r_n, r_c, r_v;

  logic [31:0] w_b;
  logic [32:0] w_add;
  logic [32:0] w_sub;
  logic [31:0] w_res;
  logic        w_arith;
  logic        w_logic;
  logic        w_c_new;
  logic        w_v_new;
  logic        w_taken;
  logic [31:0] w_target;
  logic        w_mul_start;
  logic        w_mul_ack;
  logic        w_mul_busy;
  logic        w_mul_done;
  logic [31:0] w_mul_result;

  assign w_b      = i_buf_sr2_val + i_buf_imm;
  assign w_add    = {1'b0, i_buf_sr1_val} + {1'b0, w_b};
  // Carry out of A + ~B + 1 is the "no borrow" flag.
  assign w_sub    = {1'b0, i_buf_sr1_val} + {1'b0, ~w_b} + 33'd1;
  assign w_target = i_buf_sr1_val + i_buf_imm;
  assign w_taken  = cond_met(i_buf_cond, r_z, r_n, r_c, r_v);

  // Single-cycle ALU result and the flags each op would produce.
  always_comb begin
    w_res   = 32'd0;
    w_arith = 1'b0;
    w_logic = 1'b0;
    w_c_new = r_c;
    w_v_new = r_v;
    case (i_buf_opcode)
      OP_ADD: begin
        w_res   = w_add[31:0];
        w_arith = 1'b1;
        w_c_new = w_add[32];
        w_v_new = (i_buf_sr1_val[31] == w_b[31]) && (w_add[31] != i_buf_sr1_val[31]);
      end
      OP_SUB: begin
        w_res   = w_sub[31:0];
        w_arith = 1'b1;
        w_c_new = w_sub[32];
        w_v_new = (i_buf_sr1_val[31] != w_b[31]) && (w_sub[31] != i_buf_sr1_val[31]);
      end
      OP_OR:  begin w_res = i_buf_sr1_val | w_b;          w_logic = 1'b1; end
      OP_XOR: begin w_res = i_buf_sr1_val ^ w_b;          w_logic = 1'b1; end
      OP_AND: begin w_res = i_buf_sr1_val & w_b;          w_logic = 1'b1; end
      OP_NOT: begin w_res = ~i_buf_sr1_val;               w_logic = 1'b1; end
      OP_SHL: begin w_res = i_buf_sr1_val << w_b[4:0];    w_logic = 1'b1; end
      OP_SHR: begin w_res = i_buf_sr1_val >> w_b[4:0];    w_logic = 1'b1; end
      default: begin w_res = 32'd0; end
    endcase
  end

  // A squashed MUL must not start; the result is taken only when downstream can accept it.
  assign w_mul_start = (i_buf_opcode == OP_MUL) && !r_squash;
  assign w_mul_ack   = w_mul_done && !i_pipe_stall;

  generate
    if (MUL_ENABLE != 0) begin : g_mul
      tl45_mul_iter u_mul (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (w_mul_start),
        .i_a      (i_buf_sr1_val),
        .i_b      (w_b),
        .i_ack    (w_mul_ack),
        .o_busy   (w_mul_busy),
        .o_done   (w_mul_done),
        .o_result (w_mul_result)
      );
    end else begin : g_no_mul
      assign w_mul_busy   = 1'b0;
      assign w_mul_done   = 1'b0;
      assign w_mul_result = 32'd0;
    end
  endgenerate

  // Output buffer, flags, redirect and squash; everything holds while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_opcode       <= OP_NOP;
      r_dr           <= 4'd0;
      r_sr1_val      <= 32'd0;
      r_sr2_val      <= 32'd0;
      r_imm          <= 32'd0;
      r_fwd_dr       <= 4'd0;
      r_branch_valid <= 1'b0;
      r_branch_pc    <= 32'd0;
      r_squash       <= 1'b0;
      {r_z, r_n, r_c, r_v} <= 4'b0000;
    end else if (!i_pipe_stall) begin
      r_opcode       <= OP_NOP;
      r_dr           <= 4'd0;
      r_sr1_val      <= 32'd0;
      r_sr2_val      <= 32'd0;
      r_imm          <= 32'd0;
      r_fwd_dr       <= 4'd0;
      r_branch_valid <= 1'b0;
      r_squash       <= 1'b0;
      if (!r_squash) begin
        case (i_buf_opcode)
          OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_NOT, OP_SHL, OP_SHR: begin
            r_opcode  <= i_buf_opcode;
            r_dr      <= i_buf_dr;
            r_sr1_val <= w_res;
            r_sr2_val <= i_buf_sr2_val;
            r_imm     <= i_buf_imm;
            r_fwd_dr  <= i_buf_dr;
            if (w_arith) begin
              {r_z, r_n, r_c, r_v} <= {(w_res == 32'd0), w_res[31], w_c_new, w_v_new};
            end else if (w_logic) begin
              {r_z, r_n} <= {(w_res == 32'd0), w_res[31]};
            end
          end
          OP_MUL: begin
            if (w_mul_done) begin
              r_opcode  <= i_buf_opcode;
              r_dr      <= i_buf_dr;
              r_sr1_val <= w_mul_result;
              r_sr2_val <= i_buf_sr2_val;
              r_imm     <= i_buf_imm;
              r_fwd_dr  <= i_buf_dr;
            end
          end
          OP_JMP: begin
            if (w_taken) begin
              r_branch_valid <= 1'b1;
              r_branch_pc    <= w_target;
              r_squash       <= 1'b1;
            end
          end
          OP_IN, OP_OUT, OP_LW, OP_SW: begin
            r_opcode  <= i_buf_opcode;
            r_dr      <= i_buf_dr;
            r_sr1_val <= i_buf_sr1_val;
            r_sr2_val <= i_buf_sr2_val;
            r_imm     <= i_buf_imm;
          end
          default: r_opcode <= OP_NOP;
        endcase
      end
    end
  end

  assign o_pipe_stall   = i_pipe_stall | w_mul_busy;
  assign o_buf_opcode   = r_opcode;
  assign o_buf_dr       = r_dr;
  assign o_buf_sr1_val  = r_sr1_val;
  assign o_buf_sr2_val  = r_sr2_val;
  assign o_buf_imm      = r_imm;
  assign o_fwd_dr       = r_fwd_dr;
  assign o_fwd_val      = r_sr1_val;
  assign o_branch_valid = r_branch_valid & ~i_pipe_stall;
  assign o_branch_pc    = r_branch_pc;

endmodule

// File: tb/tb_tl45_alu.sv
// Self-checking bench for tl45_alu: directed vector table, hand-written jump,
// flag, stall, multiplier and reset sequences, then random traffic against a
// behavioural model of the execute stage.
module tb_tl45_alu;

  logic        clk = 1'b0;
  logic        i_reset, i_pipe_stall, o_pipe_stall;
  logic [4:0]  i_buf_opcode, o_buf_opcode;
  logic [3:0]  i_buf_cond, i_buf_dr, o_buf_dr, o_fwd_dr;
  logic [31:0] i_buf_sr1_val, i_buf_sr2_val, i_buf_imm;
  logic [31:0] o_buf_sr1_val, o_buf_sr2_val, o_buf_imm, o_fwd_val, o_branch_pc;
  logic        o_branch_valid;

  always #5 clk = ~clk;

  tl45_alu #(.MUL_ENABLE(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall), .o_pipe_stall(o_pipe_stall),
    .i_buf_opcode(i_buf_opcode), .i_buf_cond(i_buf_cond), .i_buf_dr(i_buf_dr),
    .i_buf_sr1_val(i_buf_sr1_val), .i_buf_sr2_val(i_buf_sr2_val), .i_buf_imm(i_buf_imm),
    .o_buf_opcode(o_buf_opcode), .o_buf_dr(o_buf_dr), .o_buf_sr1_val(o_buf_sr1_val),
    .o_buf_sr2_val(o_buf_sr2_val), .o_buf_imm(o_buf_imm), .o_fwd_dr(o_fwd_dr),
    .o_fwd_val(o_fwd_val), .o_branch_valid(o_branch_valid), .o_branch_pc(o_branch_pc)
  );

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [31:0] sr1, sr2, imm;
    logic [3:0]  fwd;
  } out_t;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  dr;
    logic [31:0] a, b2, imm, exp_res;
    logic [3:0]  exp_fwd;
    logic [4:0]  exp_op;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  bit    m_z, m_n, m_c, m_v, m_bv, m_squash;
  logic [31:0] m_pc;
  out_t  m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    {m_z, m_n, m_c, m_v, m_bv, m_squash} = 6'b0;
    m_pc  = 32'd0;
    m_out = '{default: 0};
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] cond, input logic [3:0] dr,
                       input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                       input bit stall);
    i_buf_opcode = op; i_buf_cond = cond; i_buf_dr = dr;
    i_buf_sr1_val = a; i_buf_sr2_val = b2; i_buf_imm = imm; i_pipe_stall = stall;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    drive(5'h00, 4'h0, 4'h0, 32'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    m_reset();
  endtask

  // Apply one instruction for one cycle and compare every output with the model.
  task automatic run(input logic [4:0] op, input logic [3:0] cond, input logic [3:0] dr,
                     input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                     input bit stall);
    logic [31:0] bb, res;
    longint      sv;
    bit          alu, taken;
    drive(op, cond, dr, a, b2, imm, stall);
    #1;
    chk("branch_valid", {31'd0, o_branch_valid}, {31'd0, m_bv && !stall});
    if (m_bv && !stall) chk("branch_pc", o_branch_pc, m_pc);
    chk("pipe_stall", {31'd0, o_pipe_stall}, {31'd0, stall});
    @(posedge clk);
    if (!stall) begin
      m_bv = 1'b0;
      if (m_squash) begin
        m_out    = '{default: 0};
        m_squash = 1'b0;
      end else begin
        bb = b2 + imm; alu = 1'b1; res = 32'd0;
        case (op)
          5'h01: begin
            res = a + bb;
            m_c = (64'(a) + 64'(bb)) > 64'hFFFF_FFFF;
            sv  = longint'($signed(a)) + longint'($signed(bb));
            m_v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
          end
          5'h02: begin
            res = a - bb;
            m_c = (a >= bb);
            sv  = longint'($signed(a)) - longint'($signed(bb));
            m_v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
          end
          5'h06: res = a | bb;
          5'h07: res = a ^ bb;
          5'h08: res = a & bb;
          5'h09: res = ~a;
          5'h0A: res = a << (bb % 32);
          5'h0B: res = a >> (bb % 32);
          default: alu = 1'b0;
        endcase
        if (alu) begin
          m_out = '{op, dr, res, b2, imm, dr};
          m_z = (res == 32'd0); m_n = res[31];
        end else if (op == 5'h10 || op == 5'h11 || op == 5'h14 || op == 5'h15) begin
          m_out = '{op, dr, a, b2, imm, 4'd0};
        end else begin
          m_out = '{default: 0};
          if (op == 5'h0C) begin
            case (cond)
              4'h0: taken = 1'b1;
              4'h1: taken = m_z;
              4'h2: taken = !m_z;
              4'h3: taken = m_n;
              4'h4: taken = !m_n;
              4'h5: taken = m_c;
              4'h6: taken = m_v;
              default: taken = 1'b0;
            endcase
            if (taken) begin m_bv = 1'b1; m_pc = a + imm; m_squash = 1'b1; end
          end
        end
      end
    end
    #1;
    chk("opcode",  {27'd0, o_buf_opcode}, {27'd0, m_out.op});
    chk("dr",      {28'd0, o_buf_dr},     {28'd0, m_out.dr});
    chk("sr1_val", o_buf_sr1_val, m_out.sr1);
    chk("sr2_val", o_buf_sr2_val, m_out.sr2);
    chk("imm",     o_buf_imm,     m_out.imm);
    chk("fwd_dr",  {28'd0, o_fwd_dr},     {28'd0, m_out.fwd});
    chk("fwd_val", o_fwd_val,     m_out.sr1);
  endtask

  // Issue a MUL and measure stall cycles and result latency.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] dr);
    int stall_cnt = 0;
    int lat = -1;
    logic [31:0] expv;
    expv = 32'(64'(a) * 64'(b));
    drive(5'h03, 4'h0, dr, a, b, 32'd0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_pipe_stall) stall_cnt++;
      if (o_buf_opcode == 5'h03) begin lat = k - 1; break; end
    end
    drive(5'h00, 4'h0, 4'h0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("mul_latency",  lat, 33);
    chk("mul_stall_cycles", stall_cnt, 32);
    chk("mul_result",   o_buf_sr1_val, expv);
    chk("mul_fwd_dr",   {28'd0, o_fwd_dr}, {28'd0, dr});
    m_out = '{5'h03, dr, expv, b, 32'd0, dr};
  endtask

  vec_t        vecs[13];
  logic [4:0]  ops[16];

  initial begin
    vecs[0]  = '{5'h01, 4'd2,  32'd7,          32'd3,  32'd0,  32'd10,         4'd2,  5'h01};
    vecs[1]  = '{5'h02, 4'd3,  32'd5,          32'd5,  32'd0,  32'd0,          4'd3,  5'h02};
    vecs[2]  = '{5'h06, 4'd4,  32'h0F0,        32'h0F, 32'd0,  32'hFF,         4'd4,  5'h06};
    vecs[3]  = '{5'h07, 4'd5,  32'hFF,         32'h0F, 32'd0,  32'hF0,         4'd5,  5'h07};
    vecs[4]  = '{5'h08, 4'd6,  32'hFF,         32'h0F, 32'h10, 32'h1F,         4'd6,  5'h08};
    vecs[5]  = '{5'h09, 4'd7,  32'd0,          32'd0,  32'd0,  32'hFFFF_FFFF,  4'd7,  5'h09};
    vecs[6]  = '{5'h0A, 4'd8,  32'd1,          32'd31, 32'd0,  32'h8000_0000,  4'd8,  5'h0A};
    vecs[7]  = '{5'h0A, 4'd9,  32'd1,          32'd30, 32'd2,  32'd1,          4'd9,  5'h0A};
    vecs[8]  = '{5'h0B, 4'd10, 32'h8000_0000,  32'd31, 32'd0,  32'd1,          4'd10, 5'h0B};
    vecs[9]  = '{5'h01, 4'd0,  32'hFFFF_FFFF,  32'd1,  32'd0,  32'd0,          4'd0,  5'h01};
    vecs[10] = '{5'h14, 4'd5,  32'h40,         32'd0,  32'd8,  32'h40,         4'd0,  5'h14};
    vecs[11] = '{5'h1F, 4'd3,  32'd1,          32'd2,  32'd3,  32'd0,          4'd0,  5'h00};
    vecs[12] = '{5'h02, 4'd1,  32'd3,          32'd5,  32'd0,  32'hFFFF_FFFE,  4'd1,  5'h02};
    ops = '{5'h00, 5'h01, 5'h02, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
            5'h0B, 5'h0C, 5'h10, 5'h11, 5'h14, 5'h15, 5'h04, 5'h1F};

    i_reset = 1'b1;
    drive(5'h00, 4'h0, 4'h0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_opcode", {27'd0, o_buf_opcode}, 32'd0);
    chk("rst_sr1",    o_buf_sr1_val, 32'd0);
    chk("rst_fwd_dr", {28'd0, o_fwd_dr}, 32'd0);
    chk("rst_bv",     {31'd0, o_branch_valid}, 32'd0);
    chk("rst_stall",  {31'd0, o_pipe_stall}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run(vecs[i].op, 4'h0, vecs[i].dr, vecs[i].a, vecs[i].b2, vecs[i].imm, 1'b0);
      chk($sformatf("vec%0d_res", i), o_buf_sr1_val, vecs[i].exp_res);
      chk($sformatf("vec%0d_fwd", i), {28'd0, o_fwd_dr}, {28'd0, vecs[i].exp_fwd});
      chk($sformatf("vec%0d_op", i),  {27'd0, o_buf_opcode}, {27'd0, vecs[i].exp_op});
    end

    // SUB sets Z, taken JMP Z redirects, wrong-path ADD squashed
    run(5'h02, 4'h0, 4'd1, 32'd5, 32'd5, 32'd0, 1'b0);
    run(5'h0C, 4'h1, 4'd0, 32'h100, 32'd0, 32'd4, 1'b0);
    chk("jmp_bv",  {31'd0, o_branch_valid}, 32'd1);
    chk("jmp_pc",  o_branch_pc, 32'h104);
    chk("jmp_nop", {27'd0, o_buf_opcode}, 32'd0);
    run(5'h01, 4'h0, 4'd2, 32'd1, 32'd1, 32'd0, 1'b0);
    chk("squash_op",  {27'd0, o_buf_opcode}, 32'd0);
    chk("squash_fwd", {28'd0, o_fwd_dr}, 32'd0);
    run(5'h0C, 4'h2, 4'd0, 32'h300, 32'd0, 32'd0, 1'b0);
    chk("jmp_nz_not_taken", {31'd0, o_branch_valid}, 32'd0);

    // Signed overflow, then logic op keeps C and V
    run(5'h01, 4'h0, 4'd1, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0);
    chk("ovf_res", o_buf_sr1_val, 32'h8000_0000);
    run(5'h07, 4'h0, 4'd2, 32'd1, 32'd1, 32'd0, 1'b0);
    run(5'h0C, 4'h6, 4'd0, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("jmp_v_kept", {31'd0, o_branch_valid}, 32'd1);
    run(5'h00, 4'h0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    run(5'h0C, 4'h5, 4'd0, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("jmp_c_clear", {31'd0, o_branch_valid}, 32'd0);
    run(5'h0C, 4'h3, 4'd0, 32'h200, 32'd0, 32'd0, 1'b0);
    chk("jmp_n_after_xor", {31'd0, o_branch_valid}, 32'd0);

    // LW held under downstream stall
    run(5'h01, 4'h0, 4'd4, 32'd2, 32'd3, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run(5'h14, 4'h0, 4'd5, 32'h40, 32'd0, 32'd8, 1'b1);
      chk("stall_hold_op",  {27'd0, o_buf_opcode}, 32'h01);
      chk("stall_hold_val", o_buf_sr1_val, 32'd5);
    end
    run(5'h14, 4'h0, 4'd5, 32'h40, 32'd0, 32'd8, 1'b0);
    chk("lw_op",  {27'd0, o_buf_opcode}, 32'h14);
    chk("lw_sr1", o_buf_sr1_val, 32'h40);
    chk("lw_imm", o_buf_imm, 32'd8);
    chk("lw_fwd", {28'd0, o_fwd_dr}, 32'd0);

    // Multiplier
    do_mul(32'hFFFF_FFFF, 32'd3, 4'd6);
    for (int i = 0; i < 3; i++) do_mul($urandom, $urandom, 4'($urandom_range(1, 15)));

    // Reset during a multiply
    drive(5'h03, 4'h0, 4'd3, 32'd9, 32'd9, 32'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    chk("rst_mul_stall",  {31'd0, o_pipe_stall}, 32'd0);
    chk("rst_mul_opcode", {27'd0, o_buf_opcode}, 32'd0);
    chk("rst_mul_sr1",    o_buf_sr1_val, 32'd0);
    chk("rst_mul_dr",     {28'd0, o_buf_dr}, 32'd0);
    // Flags cleared: none of Z, C, V, N takes a jump
    run(5'h0C, 4'h1, 4'd0, 32'h10, 32'd0, 32'd0, 1'b0);
    chk("rst_flag_z", {31'd0, o_branch_valid}, 32'd0);
    run(5'h0C, 4'h5, 4'd0, 32'h10, 32'd0, 32'd0, 1'b0);
    chk("rst_flag_c", {31'd0, o_branch_valid}, 32'd0);
    run(5'h0C, 4'h6, 4'd0, 32'h10, 32'd0, 32'd0, 1'b0);
    chk("rst_flag_v", {31'd0, o_branch_valid}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run(ops[$urandom_range(0, 15)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ra, rb, ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom,
          ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
